sofa_plus_scan_ctrl: RTL and testbench
======================================

SOFA_PLUS_SCAN_CTRL -- requirements
Module: sofa_plus_scan_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 32, number of scan flip-flops in the driven chain (>=2).
REQ-002 Parameter CAP_CYCLES, default 1, number of functional capture clocks (1..15).
REQ-003 C  input  1  chain clock; the same clock drives every flip-flop of the chain.
REQ-004 RB  input  1  asynchronous active-low reset.
REQ-005 start  input  1  pulse; starts one load/capture/unload sequence; accepted only in IDLE.
REQ-006 pat_data  input  CHAIN_LEN  pattern to load, sampled on the accepting edge; bit i is destined for chain FF i (FF 0 = head).
REQ-007 exp_data  input  CHAIN_LEN  expected capture response, sampled with pat_data.
REQ-008 scan_out_i  input  1  Q of chain tail FF (CHAIN_LEN-1).
REQ-009 scan_in_o  output  1  drives DI of chain head FF.
REQ-010 test_en_o  output  1  drives Test_en of all chain FFs.
REQ-011 busy  output  1  high in LOAD, CAPTURE and UNLOAD.
REQ-012 done  output  1  one-cycle pulse in DONE.
REQ-013 resp_data  output  CHAIN_LEN  captured response; bit i = FF i content after capture.
REQ-014 mismatch_cnt  output  $clog2(CHAIN_LEN+1)  count of bits where resp differs from exp.
REQ-015 fail  output  1  high when mismatch_cnt != 0; valid from done until next start.

Function
REQ-016 FSM states IDLE, LOAD, CAPTURE, UNLOAD, DONE; IDLE->LOAD on start, LOAD->CAPTURE after CHAIN_LEN cycles, CAPTURE->UNLOAD after CAP_CYCLES cycles, UNLOAD->DONE after CHAIN_LEN cycles, DONE->IDLE unconditionally.
REQ-017 LOAD: test_en_o=1; scan_in_o presents pat_data MSB first, one bit per cycle, so FF i holds pat_data[i] at LOAD exit.
REQ-018 CAPTURE: test_en_o=0, scan_in_o=0.
REQ-019 UNLOAD: test_en_o=1, scan_in_o=0; scan_out_i sampled on every edge; first sampled bit lands in resp_data[CHAIN_LEN-1], last in resp_data[0].
REQ-020 Each sampled bit is compared with its exp_data counterpart in the same cycle; mismatch_cnt increments by 1 per difference, saturating at CHAIN_LEN.
REQ-021 resp_data, mismatch_cnt and fail hold their values from DONE until the next accepted start, which clears mismatch_cnt and fail.
REQ-022 start while not in IDLE is ignored; pat_data/exp_data changes after acceptance have no effect.
REQ-023 Latency: with start accepted at edge 0, done is high during the cycle after edge 2*CHAIN_LEN+CAP_CYCLES+1.
REQ-024 test_en_o and scan_in_o are registered outputs (no glitches).

Reset
REQ-025 RB low, asynchronously: state IDLE, test_en_o=0, scan_in_o=0, busy=0, done=0, resp_data=0, mismatch_cnt=0, fail=0, internal counters/shift registers 0.
REQ-026 RB asserted mid-sequence aborts it; no done pulse follows; first accepted start after release runs a full sequence.

Configuration
REQ-027 Macro SOFA_PLUS_SCAN_COMPARE_EN defined: exp_data register, comparator, mismatch_cnt and fail are implemented per REQ-020/021.
REQ-028 Macro undefined: no exp register or comparator; mismatch_cnt and fail tied 0; exp_data unused; all other behaviour unchanged.

Structure
REQ-029 Package sofa_plus_scan_pkg holds the FSM state enum and the CHAIN_LEN/CAP_CYCLES defaults.
REQ-030 One sub-module sofa_plus_scan_sr: CHAIN_LEN-bit loadable shift register reused for pattern, expect and response paths.

Verification (bench models the chain as CHAIN_LEN sofa_plus_dff instances in reset-free mode, D = ~Q; CHAIN_LEN=8, CAP_CYCLES=1)
REQ-031 start, pat_data=0xA5, exp_data=0x5A -> resp_data=0x5A, mismatch_cnt=0, fail=0, done at cycle 18.
REQ-032 start, pat_data=0xA5, exp_data=0x5B -> mismatch_cnt=1, fail=1.
REQ-033 start, pat_data=0x00, exp_data=0x00 -> mismatch_cnt=8 (saturation boundary), fail=1.
REQ-034 second start pulse at cycle 5 of a running sequence -> ignored; exactly one done, at cycle 18.
REQ-035 RB low at cycle 10 (UNLOAD) -> immediate IDLE, test_en_o=0, outputs zero, no done; next start completes normally.
REQ-036 Macro undefined build, stimulus of REQ-032 -> resp_data=0x5A, mismatch_cnt=0, fail=0.

Source files
------------

// File: rtl/sofa_plus_scan_pkg.sv
// Shared types and defaults for the scan-chain controller.
// Build option: SOFA_PLUS_SCAN_COMPARE_EN enables the response comparator.
package sofa_plus_scan_pkg;

  localparam int DEF_CHAIN_LEN  = 32;
  localparam int DEF_CAP_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sofa_plus_scan_sr.sv
// Loadable left-shift register.
// Serves as the pattern, expect and response paths of the controller.
module sofa_plus_scan_sr #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_sin};
    end
  end

  assign o_q   = r_q;
  assign o_msb = r_q[W-1];

endmodule

// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain load/capture/unload sequencer with optional response compare.
// Build option: SOFA_PLUS_SCAN_COMPARE_EN (comparator, mismatch_cnt, fail).
module sofa_plus_scan_ctrl
  import sofa_plus_scan_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CAP_CYCLES = DEF_CAP_CYCLES
) (
  input  logic                           C,
  input  logic                           RB,
  input  logic                           start,
  input  logic [CHAIN_LEN-1:0]           pat_data,
  input  logic [CHAIN_LEN-1:0]           exp_data,
  input  logic                           scan_out_i,
  output logic                           scan_in_o,
  output logic                           test_en_o,
  output logic                           busy,
  output logic                           done,
  output logic [CHAIN_LEN-1:0]           resp_data,
  output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt,
  output logic                           fail
);

  localparam int MW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(CHAIN_LEN + 16);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sample;
  logic            w_accept;
  logic            w_pat_msb;
  logic [CHAIN_LEN-1:0] w_unused_pat;
  logic            w_unused_rsp;

  assign w_accept = (r_state == ST_IDLE) && start;

  // Chain-facing outputs are decided from the current state, so the
  // chain runs one cycle behind the state register.
  always_ff @(posedge C or negedge RB) begin
    if (!RB) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sample  <= 1'b0;
      scan_in_o <= 1'b0;
      test_en_o <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_sample <= (r_state == ST_UNLOAD);
      done     <= (r_state == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          test_en_o <= 1'b0;
          scan_in_o <= 1'b0;
          busy      <= start;
          r_cnt     <= '0;
          if (start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          test_en_o <= 1'b1;
          scan_in_o <= w_pat_msb;
          busy      <= 1'b1;
          if (r_cnt == CW'(CHAIN_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_CAPTURE: begin
          test_en_o <= 1'b0;
          scan_in_o <= 1'b0;
          busy      <= 1'b1;
          if (r_cnt == CW'(CAP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_UNLOAD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_UNLOAD: begin
          test_en_o <= 1'b1;
          scan_in_o <= 1'b0;
          busy      <= 1'b1;
          if (r_cnt == CW'(CHAIN_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          test_en_o <= 1'b0;
          scan_in_o <= 1'b0;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sofa_plus_scan_sr #(.W(CHAIN_LEN)) u_pat (
    .i_clk   (C),
    .i_rst_n (RB),
    .i_load  (w_accept),
    .i_d     (pat_data),
    .i_shift (r_state == ST_LOAD),
    .i_sin   (1'b0),
    .o_q     (w_unused_pat),
    .o_msb   (w_pat_msb)
  );

  sofa_plus_scan_sr #(.W(CHAIN_LEN)) u_rsp (
    .i_clk   (C),
    .i_rst_n (RB),
    .i_load  (1'b0),
    .i_d     ('0),
    .i_shift (r_sample),
    .i_sin   (scan_out_i),
    .o_q     (resp_data),
    .o_msb   (w_unused_rsp)
  );

`ifdef SOFA_PLUS_SCAN_COMPARE_EN
  logic                 w_exp_msb;
  logic [CHAIN_LEN-1:0] w_unused_exp;
  logic [MW-1:0]        r_mcnt;

  sofa_plus_scan_sr #(.W(CHAIN_LEN)) u_exp (
    .i_clk   (C),
    .i_rst_n (RB),
    .i_load  (w_accept),
    .i_d     (exp_data),
    .i_shift (r_sample),
    .i_sin   (1'b0),
    .o_q     (w_unused_exp),
    .o_msb   (w_exp_msb)
  );

  always_ff @(posedge C or negedge RB) begin
    if (!RB) begin
      r_mcnt <= '0;
    end else if (w_accept) begin
      r_mcnt <= '0;
    end else if (r_sample && (scan_out_i != w_exp_msb)
                 && (r_mcnt != MW'(CHAIN_LEN))) begin
      r_mcnt <= r_mcnt + MW'(1);
    end
  end

  assign mismatch_cnt = r_mcnt;
  assign fail         = |r_mcnt;
`else
  logic w_unused_exp;

  assign w_unused_exp = ^exp_data;
  assign mismatch_cnt = '0;
  assign fail         = 1'b0;
`endif

endmodule

// File: tb/tb_sofa_plus_scan_ctrl.sv
// Directed bench: scan controller driving an 8-FF chain whose
// functional path is D = ~Q.
module tb_sofa_plus_scan_ctrl;

  localparam int N  = 8;
  localparam int MW = $clog2(N + 1);
`ifdef SOFA_PLUS_SCAN_COMPARE_EN
  localparam int CMP = 1;
`else
  localparam int CMP = 0;
`endif

  logic          C = 1'b0;
  logic          RB = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  pat_data = '0;
  logic [N-1:0]  exp_data = '0;
  logic          scan_out_i;
  logic          scan_in_o;
  logic          test_en_o;
  logic          busy;
  logic          done;
  logic [N-1:0]  resp_data;
  logic [MW-1:0] mismatch_cnt;
  logic          fail;

  logic [N-1:0]  chain = '0;
  int            n_run = 0;
  int            n_fail = 0;
  int            dcnt;
  int            dk;

  always #5 C = ~C;

  // Chain model: scan shift when Test_en, else capture inverted Q.
  always @(posedge C) begin
    if (test_en_o) chain <= {chain[N-2:0], scan_in_o};
    else           chain <= ~chain;
  end
  assign scan_out_i = chain[N-1];

  sofa_plus_scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(1)) dut (
    .C            (C),
    .RB           (RB),
    .start        (start),
    .pat_data     (pat_data),
    .exp_data     (exp_data),
    .scan_out_i   (scan_out_i),
    .scan_in_o    (scan_in_o),
    .test_en_o    (test_en_o),
    .busy         (busy),
    .done         (done),
    .resp_data    (resp_data),
    .mismatch_cnt (mismatch_cnt),
    .fail         (fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] ex);
    n_run++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_te"}, test_en_o, 0);
    chk({tag, "_si"}, scan_in_o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_resp"}, resp_data, 0);
    chk({tag, "_mcnt"}, mismatch_cnt, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask

  task automatic run(input logic [N-1:0] p, input logic [N-1:0] ev,
                     input int ign_at, input int rst_at, input bit probe,
                     output int nd, output int kd);
    @(negedge C);
    pat_data = p;
    exp_data = ev;
    start    = 1'b1;
    @(posedge C);
    #1;
    start = 1'b0;
    nd = 0;
    kd = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge C);
      #1;
      if (done) begin
        nd++;
        kd = k;
      end
      if (probe) begin
        if (k == 1) begin
          chk("load_te", test_en_o, 1);
          chk("load_si_msb", scan_in_o, p[N-1]);
        end
        if (k == 5)  chk("busy_mid", busy, 1);
        if (k == 9)  chk("capture_te", test_en_o, 0);
        if (k == 10) begin
          chk("unload_te", test_en_o, 1);
          chk("unload_si", scan_in_o, 0);
        end
        if (k == 18) chk("busy_at_done", busy, 0);
      end
      if (k == ign_at) begin
        start    = 1'b1;
        pat_data = ~p;
        exp_data = ~ev;
      end
      if (k == ign_at + 1) start = 1'b0;
      if (k == rst_at) begin
        RB = 1'b0;
        #1;
        chk_zero("midrst");
        #2;
        RB = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge C);
    #1;
    chk_zero("reset");
    @(negedge C);
    RB = 1'b1;

    run(8'hA5, 8'h5A, -1, -1, 1'b1, dcnt, dk);
    chk("a5_done_cnt", dcnt, 1);
    chk("a5_done_cycle", dk, 18);
    chk("a5_resp", resp_data, 8'h5A);
    chk("a5_mcnt", mismatch_cnt, 0);
    chk("a5_fail", fail, 0);

    run(8'hA5, 8'h5B, -1, -1, 1'b0, dcnt, dk);
    chk("one_resp", resp_data, 8'h5A);
    chk("one_mcnt", mismatch_cnt, CMP);
    chk("one_fail", fail, CMP);

    run(8'h00, 8'h00, -1, -1, 1'b0, dcnt, dk);
    chk("sat_resp", resp_data, 8'hFF);
    chk("sat_mcnt", mismatch_cnt, 8 * CMP);
    chk("sat_fail", fail, CMP);

    run(8'hA5, 8'h5A, 5, -1, 1'b0, dcnt, dk);
    chk("ign_done_cnt", dcnt, 1);
    chk("ign_done_cycle", dk, 18);
    chk("ign_resp", resp_data, 8'h5A);
    chk("ign_mcnt", mismatch_cnt, 0);

    run(8'hA5, 8'h5B, -1, 10, 1'b0, dcnt, dk);
    chk("rst_done_cnt", dcnt, 0);
    chk("rst_resp", resp_data, 0);

    run(8'h3C, 8'hC0, -1, -1, 1'b0, dcnt, dk);
    chk("post_done_cnt", dcnt, 1);
    chk("post_done_cycle", dk, 18);
    chk("post_resp", resp_data, 8'hC3);
    chk("post_mcnt", mismatch_cnt, 2 * CMP);
    chk("post_fail", fail, CMP);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
